// File: rtl/idct_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : idct_pkg
// Purpose  : Shared widths, FSM state type and the 8x8 fixed-point cosine
//            table for the sequential 8-point inverse DCT.
// Contents : COEFF_W, SAMPLE_W, ACC_W, TBL_W, state_t, C_COS_TBL
// Revision : 1.0  initial release
// ============================================================================
package idct_pkg;

    localparam int COEFF_W  = 18;   // signed DCT coefficient width
    localparam int SAMPLE_W = 8;    // signed reconstructed sample width
    localparam int ACC_W    = 30;   // accumulator width, overflow-free
    localparam int TBL_W    = 9;    // signed cosine table entry width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // C_COS_TBL[n][k] = round(128 * c_k * cos((2n+1) k pi / 16)),
    // c_0 = 1/sqrt(2), c_k = 1 otherwise. Row 7-n equals row n with the
    // odd-k columns negated.
    localparam logic signed [TBL_W-1:0] C_COS_TBL [0:7][0:7] = '{
        '{9'sd91,  9'sd126,  9'sd118,  9'sd106,  9'sd91,  9'sd71,  9'sd49,  9'sd25},
        '{9'sd91,  9'sd106,  9'sd49,  -9'sd25,  -9'sd91, -9'sd126, -9'sd118, -9'sd71},
        '{9'sd91,  9'sd71,  -9'sd49,  -9'sd126, -9'sd91,  9'sd25,  9'sd118, 9'sd106},
        '{9'sd91,  9'sd25,  -9'sd118, -9'sd71,   9'sd91,  9'sd106, -9'sd49, -9'sd126},
        '{9'sd91, -9'sd25,  -9'sd118,  9'sd71,   9'sd91, -9'sd106, -9'sd49,  9'sd126},
        '{9'sd91, -9'sd71,  -9'sd49,   9'sd126, -9'sd91, -9'sd25,  9'sd118, -9'sd106},
        '{9'sd91, -9'sd106,  9'sd49,   9'sd25,  -9'sd91,  9'sd126, -9'sd118, 9'sd71},
        '{9'sd91, -9'sd126,  9'sd118, -9'sd106,  9'sd91, -9'sd71,  9'sd49,  -9'sd25}
    };

endpackage : idct_pkg
`default_nettype wire

// File: rtl/idct_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : idct_mac
// Purpose  : Shared multiply-accumulate unit of the IDCT. Multiplies one
//            coefficient by one table entry per enabled cycle, accumulates,
//            and presents the rounded, saturated value of (acc + term).
// Ports    : clk, reset (sync, active-low)
//            i_clr    - clear accumulator (new block accepted)
//            i_en     - perform one MAC this cycle
//            i_last   - last term of a row: accumulator restarts at zero
//            i_coef   - signed coefficient X[k]
//            i_tbl    - signed table entry T[n][k]
//            o_sample - sat(round((acc + term) / 256))
//            o_sat    - o_sample was clipped
// Revision : 1.0  initial release
// ============================================================================
module idct_mac #(
    parameter int COEFF_W  = idct_pkg::COEFF_W,
    parameter int SAMPLE_W = idct_pkg::SAMPLE_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_clr,
    input  logic                              i_en,
    input  logic                              i_last,
    input  logic signed [COEFF_W-1:0]         i_coef,
    input  logic signed [idct_pkg::TBL_W-1:0] i_tbl,
    output logic signed [SAMPLE_W-1:0]        o_sample,
    output logic                              o_sat
);
    import idct_pkg::*;

    localparam int PROD_W = COEFF_W + TBL_W;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_rnd;
    logic signed [ACC_W-1:0]  w_shift;
    logic                     w_pos_ovf;
    logic                     w_neg_ovf;

    assign w_prod  = PROD_W'(i_coef) * PROD_W'(i_tbl);
    assign w_sum   = r_acc + ACC_W'(w_prod);
    // Add half an LSB of the output scale, then floor via arithmetic shift.
    assign w_rnd   = w_sum + ACC_W'(128);
    assign w_shift = w_rnd >>> 8;

    // The value fits SAMPLE_W bits only when every bit above the sample's
    // sign bit equals the overall sign.
    assign w_pos_ovf = ~w_shift[ACC_W-1] &  (|w_shift[ACC_W-2:SAMPLE_W-1]);
    assign w_neg_ovf =  w_shift[ACC_W-1] & ~(&w_shift[ACC_W-2:SAMPLE_W-1]);

    assign o_sample = w_pos_ovf ? {1'b0, {(SAMPLE_W-1){1'b1}}} :
                      w_neg_ovf ? {1'b1, {(SAMPLE_W-1){1'b0}}} :
                                  w_shift[SAMPLE_W-1:0];
    assign o_sat    = w_pos_ovf | w_neg_ovf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_last ? '0 : w_sum;
        end
    end

endmodule : idct_mac
`default_nettype wire

// File: rtl/idct_8pt_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : idct_8pt_seq
// Purpose  : Sequential 8-point inverse DCT. Accepts a block of eight signed
//            coefficients, reconstructs eight signed samples with one shared
//            MAC over 64 cycles, and holds the result until the sink takes it.
// Ports    : clk, reset (sync, active-low)
//            in_valid / in_ready   - coefficient block handshake
//            coeff0..coeff7        - signed coefficients X[0]..X[7]
//            out_valid / out_ready - sample block handshake
//            sample0..sample7      - signed samples x[0]..x[7]
//            sat_flag              - some sample of the block was clipped
//                                    (only with IDCT_SAT_FLAG_EN defined)
// Options  : IDCT_SAT_FLAG_EN - adds the sat_flag output
// Revision : 1.0  initial release
// ============================================================================
module idct_8pt_seq #(
    parameter int COEFF_W  = idct_pkg::COEFF_W,
    parameter int SAMPLE_W = idct_pkg::SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [COEFF_W-1:0]  coeff0,
    input  logic signed [COEFF_W-1:0]  coeff1,
    input  logic signed [COEFF_W-1:0]  coeff2,
    input  logic signed [COEFF_W-1:0]  coeff3,
    input  logic signed [COEFF_W-1:0]  coeff4,
    input  logic signed [COEFF_W-1:0]  coeff5,
    input  logic signed [COEFF_W-1:0]  coeff6,
    input  logic signed [COEFF_W-1:0]  coeff7,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef IDCT_SAT_FLAG_EN
    output logic                       sat_flag,
`endif
    output logic signed [SAMPLE_W-1:0] sample0,
    output logic signed [SAMPLE_W-1:0] sample1,
    output logic signed [SAMPLE_W-1:0] sample2,
    output logic signed [SAMPLE_W-1:0] sample3,
    output logic signed [SAMPLE_W-1:0] sample4,
    output logic signed [SAMPLE_W-1:0] sample5,
    output logic signed [SAMPLE_W-1:0] sample6,
    output logic signed [SAMPLE_W-1:0] sample7
);
    import idct_pkg::*;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [2:0]                 r_n;
    logic [2:0]                 r_k;
    logic signed [COEFF_W-1:0]  r_coef   [0:7];
    logic signed [SAMPLE_W-1:0] r_sample [0:7];

    logic                       w_accept;
    logic                       w_mac_en;
    logic                       w_mac_last;
    logic signed [SAMPLE_W-1:0] w_mac_sample;
    logic                       w_mac_sat;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_mac_en    = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by reset so no block is offered while reset is low.
                in_ready = reset;
                if (in_valid && reset) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_mac_en = 1'b1;
                if (r_n == 3'd7 && r_k == 3'd7) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept   = in_valid & in_ready;
    assign w_mac_last = (r_k == 3'd7);

    // ------------------------------------------------------------------
    // Counters, coefficient capture and sample write-back
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_n <= '0;
            r_k <= '0;
            for (int i = 0; i < 8; i++) begin
                r_coef[i]   <= '0;
                r_sample[i] <= '0;
            end
        end else if (w_accept) begin
            r_n       <= '0;
            r_k       <= '0;
            r_coef[0] <= coeff0;
            r_coef[1] <= coeff1;
            r_coef[2] <= coeff2;
            r_coef[3] <= coeff3;
            r_coef[4] <= coeff4;
            r_coef[5] <= coeff5;
            r_coef[6] <= coeff6;
            r_coef[7] <= coeff7;
        end else if (w_mac_en) begin
            // k wraps 7 -> 0 naturally; n does the same after the final row.
            r_k <= r_k + 3'd1;
            if (w_mac_last) begin
                r_n           <= r_n + 3'd1;
                r_sample[r_n] <= w_mac_sample;
            end
        end
    end

`ifdef IDCT_SAT_FLAG_EN
    logic r_sat_flag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sat_flag <= 1'b0;
        end else if (w_accept) begin
            r_sat_flag <= 1'b0;
        end else if (w_mac_en && w_mac_last && w_mac_sat) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_mac_sat;
`endif

    // ------------------------------------------------------------------
    // Shared MAC
    // ------------------------------------------------------------------
    idct_mac #(
        .COEFF_W  (COEFF_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_accept),
        .i_en     (w_mac_en),
        .i_last   (w_mac_last),
        .i_coef   (r_coef[r_k]),
        .i_tbl    (C_COS_TBL[r_n][r_k]),
        .o_sample (w_mac_sample),
        .o_sat    (w_mac_sat)
    );

    assign sample0 = r_sample[0];
    assign sample1 = r_sample[1];
    assign sample2 = r_sample[2];
    assign sample3 = r_sample[3];
    assign sample4 = r_sample[4];
    assign sample5 = r_sample[5];
    assign sample6 = r_sample[6];
    assign sample7 = r_sample[7];

endmodule : idct_8pt_seq
`default_nettype wire
